// File: rtl/nexys_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : nexys_step_ctrl
// Brief   : Debounced STEP/RUN execution controller issuing one-cycle core
//           clock-enable pulses. Optional breakpoint compare: NEXYS_STEP_BREAKPOINT_EN
// Revision: 1.0 - initial release
// ============================================================================
module nexys_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RATE_BASE       = 100_000,
    parameter int DIV_W           = 32
) (
    input  logic        CLK100,
    input  logic        resetn,
    input  logic        btn_step_i,
    input  logic        btn_run_i,
    input  logic [2:0]  rate_sel_i,
    input  logic        halt_i,
`ifdef NEXYS_STEP_BREAKPOINT_EN
    input  logic [31:0] pc_i,
    input  logic [31:0] bp_addr_i,
    input  logic        bp_valid_i,
`endif
    output logic        cpu_en_o,
    output logic [1:0]  mode_o,
    output logic [31:0] step_cnt_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_db_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_STEP = 2'b01,
        ST_RUN  = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    logic [1:0] w_btn_raw;
    logic [1:0] w_press;
    logic       w_step_p;
    logic       w_run_p;
    logic       w_halt;

    assign w_btn_raw = {btn_run_i, btn_step_i};

    // Index 0 is STEP, index 1 is RUN; a press is the debounced level rising.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [1:0]       r_sync;
        logic             r_deb;
        logic             r_press;
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge CLK100 or negedge resetn) begin
            if (!resetn) begin
                r_sync  <= 2'b00;
                r_deb   <= 1'b0;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync  <= {r_sync[0], w_btn_raw[gi]};
                r_press <= 1'b0;
                if (r_sync[1] == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_last) begin
                    r_cnt   <= '0;
                    r_deb   <= r_sync[1];
                    r_press <= r_sync[1];
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    assign w_step_p = w_press[0];
    assign w_run_p  = w_press[1];

`ifdef NEXYS_STEP_BREAKPOINT_EN
    assign w_halt = halt_i | (bp_valid_i & (pc_i == bp_addr_i));
`else
    assign w_halt = halt_i;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_period_m1;
    logic             r_cpu_en;
    logic             w_en_nxt;
    logic [31:0]      r_step_cnt;

    // Period is resampled every cycle, so a shorter rate fires as soon as the divider is past it.
    assign w_period_m1 = (DIV_W'(RATE_BASE) << rate_sel_i) - DIV_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = '0;
        w_en_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_run_p) begin
                    w_state_nxt = ST_RUN;
                end else if (w_step_p) begin
                    w_state_nxt = ST_STEP;
                    w_en_nxt    = 1'b1;
                end
            end
            ST_STEP: begin
                w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (w_run_p) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_halt) begin
                    w_state_nxt = ST_HALT;
                end else if (r_div >= w_period_m1) begin
                    w_en_nxt = 1'b1;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            ST_HALT: begin
                if (w_run_p) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_step_p) begin
                    w_state_nxt = ST_STEP;
                    w_en_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100 or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_cpu_en   <= 1'b0;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_cpu_en   <= w_en_nxt;
            r_step_cnt <= r_step_cnt + 32'(r_cpu_en);
        end
    end

    assign cpu_en_o   = r_cpu_en;
    assign mode_o     = r_state;
    assign step_cnt_o = r_step_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nexys_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_nexys_step_ctrl
// Brief   : Scoreboard bench for nexys_step_ctrl; pulse times predicted from
//           button timing and rate rules. Breakpoint part: NEXYS_STEP_BREAKPOINT_EN
// Revision: 1.0 - initial release
// ============================================================================
module tb_nexys_step_ctrl;

    localparam int D  = 4;
    localparam int RB = 2;

    logic        CLK100     = 1'b0;
    logic        resetn     = 1'b0;
    logic        btn_step_i = 1'b0;
    logic        btn_run_i  = 1'b0;
    logic [2:0]  rate_sel_i = 3'd0;
    logic        halt_i     = 1'b0;
`ifdef NEXYS_STEP_BREAKPOINT_EN
    logic [31:0] pc_i       = 32'h0;
    logic [31:0] bp_addr_i  = 32'h0;
    logic        bp_valid_i = 1'b0;
`endif
    logic        cpu_en_o;
    logic [1:0]  mode_o;
    logic [31:0] step_cnt_o;

    nexys_step_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .RATE_BASE      (RB),
        .DIV_W          (32)
    ) dut (
        .CLK100    (CLK100),
        .resetn    (resetn),
        .btn_step_i(btn_step_i),
        .btn_run_i (btn_run_i),
        .rate_sel_i(rate_sel_i),
        .halt_i    (halt_i),
`ifdef NEXYS_STEP_BREAKPOINT_EN
        .pc_i      (pc_i),
        .bp_addr_i (bp_addr_i),
        .bp_valid_i(bp_valid_i),
`endif
        .cpu_en_o  (cpu_en_o),
        .mode_o    (mode_o),
        .step_cnt_o(step_cnt_o)
    );

    always #5 CLK100 = ~CLK100;

    int cyc = 0;
    always @(posedge CLK100) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int unsigned cnt;
        logic [1:0]  mode;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned exp_cnt   = 0;
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          last_fall[2] = '{-100, -100};

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every cpu_en_o pulse must match the head of the expectation queue.
    always @(negedge CLK100) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_checks++;
            $display("FAIL missing_pulse: actual none, required pulse at cycle %0d (now %0d)", exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (resetn && cpu_en_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: actual cpu_en_o=1 at cycle %0d, required 0", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_step_cnt", step_cnt_o, e.cnt);
                chk("pulse_mode", mode_o, e.mode);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK100);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(negedge CLK100);
            #1;
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        if (which == 0) btn_step_i = v;
        else            btn_run_i  = v;
    endtask

    // Rise only once the previous release has fully debounced back to 0.
    task automatic rise(input int which, output int k);
        wait_until(last_fall[which] + D + 4);
        set_btn(which, 1'b1);
        k = cyc;
    endtask

    task automatic fall(input int which);
        set_btn(which, 1'b0);
        last_fall[which] = cyc;
    endtask

    task automatic push_pulse(input int c, input logic [1:0] m);
        exp_t e;
        e.cyc  = c;
        e.cnt  = exp_cnt;
        e.mode = m;
        exp_q.push_back(e);
        exp_cnt++;
    endtask

    // A raw edge after posedge k is accepted D+2 cycles later; the core pulse follows one cycle after.
    task automatic step_press(input int glitch, input int hold, input logic [1:0] pre_mode);
        int k;
        chk("mode_before_step", mode_o, pre_mode);
        if (glitch > 0) begin
            rise(0, k);
            tick(glitch);
            fall(0);
        end
        rise(0, k);
        push_pulse(k + D + 3, 2'b01);
        tick(hold);
        fall(0);
        tick(D + 4);
        chk("mode_after_step", mode_o, 2'b00);
        chk("cnt_after_step", step_cnt_o, exp_cnt);
    endtask

    // stop_kind: 0 RUN press, 1 halt_i, 2 breakpoint, 3 reset. s_off: cycle of the stop
    // condition relative to RUN entry. Callers keep any rate change before the stop action.
    task automatic run_session(input int rate1, input int chg_off, input int rate2,
                               input int stop_kind, input int s_off, input int recover);
        int k, k2, e_cyc, s, c_chg, last, p;
        rate_sel_i = 3'(rate1);
        rise(1, k);
        e_cyc = k + D + 3;
        s     = e_cyc + s_off;
        c_chg = (chg_off >= 0) ? e_cyc + chg_off : 32'h7fff_ffff;
        last  = e_cyc;
        for (int t = e_cyc; t < s; t++) begin
            p = RB << ((t >= c_chg) ? rate2 : rate1);
            if (t - last >= p - 1) begin
                push_pulse(t + 1, 2'b10);
                last = t + 1;
            end
        end
        tick(D + 1);
        fall(1);
        if (chg_off >= 0) begin
            wait_until(c_chg);
            rate_sel_i = 3'(rate2);
        end
        case (stop_kind)
            0: begin
                wait_until(s - D - 2);
                rise(1, k2);
                tick(D + 1);
                fall(1);
                tick(D + 4);
                chk("mode_after_run_stop", mode_o, 2'b00);
                chk("cnt_after_run_stop", step_cnt_o, exp_cnt);
            end
            3: begin
                wait_until(s - 1);
                rise(0, k2);
                rise(1, k2);
                wait_until(s);
                resetn  = 1'b0;
                exp_cnt = 0;
                #1;
                chk("rst_cpu_en", cpu_en_o, 0);
                chk("rst_mode", mode_o, 2'b00);
                chk("rst_step_cnt", step_cnt_o, 0);
                tick(2);
                fall(0);
                fall(1);
                tick(2);
                resetn = 1'b1;
                tick(20);
                chk("mode_after_reset", mode_o, 2'b00);
                chk("cnt_after_reset", step_cnt_o, 0);
            end
            default: begin
                wait_until(s);
                if (stop_kind == 1) halt_i = 1'b1;
`ifdef NEXYS_STEP_BREAKPOINT_EN
                else pc_i = 32'h10;
`endif
                tick($urandom_range(1, 3));
                halt_i = 1'b0;
                tick(2);
                chk("mode_halted", mode_o, 2'b11);
                chk("cnt_halted", step_cnt_o, exp_cnt);
                if (recover == 0) begin
                    step_press(0, D + 2, 2'b11);
                end else begin
                    rise(1, k2);
                    tick(D + 1);
                    fall(1);
                    tick(D + 4);
                    chk("mode_halt_to_idle", mode_o, 2'b00);
                    chk("cnt_halt_to_idle", step_cnt_o, exp_cnt);
                end
            end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned c0;
        int rate, kind, s_off, chg, maxc, p;
        tick(2);
        chk("reset_cpu_en", cpu_en_o, 0);
        chk("reset_mode", mode_o, 2'b00);
        chk("reset_step_cnt", step_cnt_o, 0);
        resetn = 1'b1;
        tick(2);

        // Short glitch, then a long hold: one pulse only.
        step_press(3, 50, 2'b00);
        chk("cnt_first_step", step_cnt_o, 1);
        for (int i = 0; i < 3; i++)
            step_press($urandom_range(0, D - 1), $urandom_range(D, 30), 2'b00);

        // P=4, stopped after exactly five pulses.
        c0 = exp_cnt;
        run_session(1, -1, 0, 0, 20 + $urandom_range(0, 3), 0);
        chk("run_five_pulses", step_cnt_o, c0 + 5);

        // Halt lands on a divider terminal cycle; STEP then moves past it.
        run_session(1, -1, 0, 1, 4 * $urandom_range(0, 3) + 3, 0);

        // P=16 down to P=2 at divider 10.
        c0 = exp_cnt;
        run_session(3, 10, 0, 0, 30, 0);
        chk("rate_change_pulses", step_cnt_o, c0 + 10);

        for (int i = 0; i < 6; i++) begin
            rate = $urandom_range(0, 3);
            p    = RB << rate;
            kind = $urandom_range(0, 1);
            s_off = (kind == 0) ? $urandom_range(12, 12 + 3 * p) : $urandom_range(0, 4 * p);
            maxc  = (kind == 0) ? s_off - D - 2 : s_off;
            chg   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, maxc) : -1;
            run_session(rate, chg, $urandom_range(0, 3), kind, s_off, $urandom_range(0, 1));
        end

        // Reset mid-RUN with both buttons held.
        run_session($urandom_range(0, 2), -1, 0, 3, 7 + $urandom_range(0, 10), 0);
        step_press(0, D + 3, 2'b00);
        chk("cnt_step_after_reset", step_cnt_o, 1);

`ifdef NEXYS_STEP_BREAKPOINT_EN
        bp_addr_i  = 32'h10;
        bp_valid_i = 1'b1;
        pc_i       = 32'h0C;
        run_session(1, -1, 0, 2, 10, 0);
        pc_i       = 32'h14;
        bp_valid_i = 1'b0;
`endif

        tick(5);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
